alu_exec_seq: RTL and testbench
===============================

# alu_exec_seq

Parametrised ALU execute stage with built-in control decode. It replaces the separate ALU-control decoder plus combinational ALU with one block. The block decodes `ALUop`/`Funct` into a 4-bit ALU control code and executes the operation. Single-cycle operations take one cycle; multiply and divide run on iterative shift-add and restoring-divide datapaths. A valid/ready handshake on each side lets the MIPS32 pipeline stall on long operations.

## Interface
- `WIDTH`, default 32: operand and result width; must be ≥ 4.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  operation request.
- `in_ready`  out  1  block can accept a request; equals (state == IDLE).
- `ALUop`  in  2  main-control op class: 00 = LW/SW, 01 = BEQ, 10 = R-type, 11 = ORI.
- `Funct`  in  6  R-type function field.
- `A`, `B`  in  WIDTH each  operands.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer takes the result.
- `Result`  out  WIDTH  operation result.
- `ALUcont`  out  4  decoded control code of the current result.
- `Zero`  out  1  (Result == 0).
- `DivByZero`  out  1  set when the result came from a divide with B == 0.

## Operation
- Decode of `ALUop`/`Funct` to `ALUcont` and operation:
  - `ALUop` 00 → 2, add.
  - `ALUop` 01 → 6, sub.
  - `ALUop` 11 → 1, or.
  - `ALUop` 10 → decode `Funct`:
    - 100000 → 2, add.
    - 100010 → 6, sub.
    - 100100 → 0, and.
    - 100101 → 1, or.
    - 101010 → 7, slt (signed; Result = 1 or 0).
    - 011000 → 3, mul.
    - 011010 → 4, div.
    - Any other `Funct` → 0, and.
- FSM states: IDLE, MUL, DIV, DONE.
  - IDLE, on `in_valid`:
    - Single-cycle op, or div with B == 0 → compute, register outputs, go to DONE.
    - mul → latch A and B, clear the accumulator, set the counter to WIDTH, go to MUL.
    - div with B != 0 → latch A and B, clear the remainder, set the counter to WIDTH, go to DIV.
  - MUL: each cycle, if multiplier bit0 is set, add the multiplicand to the accumulator; shift the multiplicand left and the multiplier right; decrement the counter. When the counter reaches 0, go to DONE.
  - DIV: unsigned restoring division, one quotient bit per cycle, MSB first. When the counter reaches 0, go to DONE.
  - DONE: `out_valid` = 1; outputs are held stable. On `out_ready`, go to IDLE.
- Arithmetic rules:
  - All add/sub wrap modulo 2^WIDTH.
  - mul returns the low WIDTH bits of the unsigned product.
  - div returns the unsigned quotient; the remainder is discarded.
  - Divide by zero: Result = all ones, `DivByZero` = 1.
- `DivByZero` is cleared on every new accepted op.
- The counter width is $clog2(WIDTH)+1.

## Timing
- Accept on the edge where `in_valid` && `in_ready`.
- Latency, counted from the accept edge:
  - Single-cycle ops and div-by-zero: `out_valid` rises after 1 edge.
  - mul and div: `out_valid` rises after WIDTH+1 edges.
- Handshake:
  - The result transfers on the edge where `out_valid` && `out_ready`.
  - `in_ready` rises the same edge; minimum spacing between ops is 2 cycles.
  - `in_ready` is 0 in MUL, DIV and DONE. Requests in those states are ignored; the requester must hold them.
  - Backpressure: `Result`, `ALUcont`, `Zero` and `DivByZero` are held unchanged while `out_valid` && !`out_ready`.
  - `out_ready` outside DONE has no effect.
- Reset values: state IDLE, `in_ready` 1, `out_valid` 0, `Result` 0, `ALUcont` 0, `Zero` 1, `DivByZero` 0.
- Reset asserted mid-MUL/DIV aborts the operation: no `out_valid`, and the partial result is lost.
- Operand inputs are sampled only at accept; changes to them afterwards have no effect.

## Configuration
- `ALU_EXEC_SEQ_DIV_EN` defined:
  - DIV state and restoring-divide datapath are present.
  - `Funct` 011010 decodes to code 4.
- `ALU_EXEC_SEQ_DIV_EN` not defined:
  - No DIV state and no divider logic.
  - `Funct` 011010 falls to the default decode (code 0, and, latency 1).
  - `DivByZero` is tied to 0.

## Test plan
All scenarios use WIDTH = 32; T is the accept edge.
- Add: `ALUop`=10, `Funct`=100000, A=5, B=7 → at T+1: `out_valid`=1, `Result`=12, `ALUcont`=2, `Zero`=0.
- Beq sub: `ALUop`=01, A=B=3 → at T+1: `Result`=0, `ALUcont`=6, `Zero`=1. SLT with A=0xFFFFFFFF, B=1 → `Result`=1, `ALUcont`=7.
- Multiply: A=0x00010003, B=5 → `in_ready`=0 through T+32; at T+33: `out_valid`=1, `Result`=0x0005000F, `ALUcont`=3.
- Divide, macro on:
  - A=100, B=7 → at T+33: `Result`=14, `ALUcont`=4, `DivByZero`=0.
  - A=9, B=0 → at T+1: `Result`=0xFFFFFFFF, `DivByZero`=1.
  - Macro off, A=100, B=7 → at T+1: `Result`=100 & 7 = 4, `ALUcont`=0.
- Backpressure: complete an add with `out_ready`=0 for 5 cycles → outputs stable and `in_ready`=0 throughout; `out_ready`=1 → next edge `out_valid`=0, `in_ready`=1.
- Reset mid-op: accept mul, assert `rst_n`=0 at T+10 → immediately `out_valid`=0, `in_ready`=1, `Result`=0. After release, a new add completes normally.

Source files
------------

// File: rtl/alu_exec_seq.sv
// alu_exec_seq: ALU execute stage that decodes ALUop/Funct into a 4-bit control
//   code and executes it. Single-cycle ops finish in one cycle. Multiply uses an
//   iterative shift-add datapath. Divide uses an iterative restoring datapath and
//   is present only when ALU_EXEC_SEQ_DIV_EN is defined.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid, in_ready   request handshake; ALUop, Funct, A, B are sampled on accept
//   out_valid, out_ready result handshake; Result, ALUcont, Zero, DivByZero are held
//                        stable while out_valid && !out_ready
module alu_exec_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       ALUop,
    input  logic [5:0]       Funct,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Result,
    output logic [3:0]       ALUcont,
    output logic             Zero,
    output logic             DivByZero
);
    localparam int CW = $clog2(WIDTH) + 1;
`ifdef ALU_EXEC_SEQ_DIV_EN
    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
`else
    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
`endif
    state_t           state_q;
    logic [WIDTH-1:0] result_q, acc_q, opa_q, opb_q, alu_d, acc_d;
    logic [CW-1:0]    cnt_q;
    logic [3:0]       cont_q, cont_d;
    // acc_q is the product accumulator in MUL and the partial remainder in DIV.
    // opa_q is the multiplicand (shifts left) or the dividend/quotient (shifts left).
    // opb_q is the multiplier (shifts right) or the divisor.
    always_comb begin
        cont_d = ALUop == 2'b00 ? 4'd2 :
                 ALUop == 2'b01 ? 4'd6 :
                 ALUop == 2'b11 ? 4'd1 :
                 Funct == 6'b100000 ? 4'd2 :
                 Funct == 6'b100010 ? 4'd6 :
                 Funct == 6'b100101 ? 4'd1 :
                 Funct == 6'b101010 ? 4'd7 :
                 Funct == 6'b011000 ? 4'd3 :
`ifdef ALU_EXEC_SEQ_DIV_EN
                 Funct == 6'b011010 ? 4'd4 :
`endif
                 4'd0;
        // Code 4 only reaches this single-cycle path when B == 0 (divide by zero).
        alu_d = cont_d == 4'd2 ? A + B :
                cont_d == 4'd6 ? A - B :
                cont_d == 4'd1 ? A | B :
                cont_d == 4'd7 ? {{(WIDTH-1){1'b0}}, $signed(A) < $signed(B)} :
                cont_d == 4'd4 ? '1 :
                A & B;
        acc_d = acc_q + (opb_q[0] ? opa_q : '0);
    end
`ifdef ALU_EXEC_SEQ_DIV_EN
    logic [WIDTH:0] sh, diff;
    logic           ge, dbz_q;
    // The remainder stays below the divisor, so the shifted value fits in
    // WIDTH+1 bits and the top bit of the difference is a clean borrow flag.
    always_comb begin
        sh   = {acc_q, opa_q[WIDTH-1]};
        diff = sh - {1'b0, opb_q};
        ge   = !diff[WIDTH];
    end
    assign DivByZero = dbz_q;
`else
    assign DivByZero = 1'b0;
`endif
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            result_q <= '0;
            cont_q   <= '0;
            acc_q    <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            cnt_q    <= '0;
`ifdef ALU_EXEC_SEQ_DIV_EN
            dbz_q    <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: if (in_valid) begin
                    cont_q <= cont_d;
                    acc_q  <= '0;
                    opa_q  <= A;
                    opb_q  <= B;
                    cnt_q  <= CW'(WIDTH);
`ifdef ALU_EXEC_SEQ_DIV_EN
                    dbz_q  <= cont_d == 4'd4 && B == '0;
`endif
                    if (cont_d == 4'd3)
                        state_q <= MUL;
`ifdef ALU_EXEC_SEQ_DIV_EN
                    else if (cont_d == 4'd4 && B != '0)
                        state_q <= DIV;
`endif
                    else begin
                        result_q <= alu_d;
                        state_q  <= DONE;
                    end
                end
                MUL: begin
                    acc_q <= acc_d;
                    opa_q <= opa_q << 1;
                    opb_q <= opb_q >> 1;
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        result_q <= acc_d;
                        state_q  <= DONE;
                    end
                end
`ifdef ALU_EXEC_SEQ_DIV_EN
                DIV: begin
                    acc_q <= ge ? diff[WIDTH-1:0] : sh[WIDTH-1:0];
                    opa_q <= {opa_q[WIDTH-2:0], ge};
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        result_q <= {opa_q[WIDTH-2:0], ge};
                        state_q  <= DONE;
                    end
                end
`endif
                DONE: if (out_ready) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
    assign in_ready  = state_q == IDLE;
    assign out_valid = state_q == DONE;
    assign Result    = result_q;
    assign ALUcont   = cont_q;
    assign Zero      = result_q == '0;
endmodule

// File: tb/tb_alu_exec_seq.sv
// tb_alu_exec_seq: directed-vector bench for alu_exec_seq at WIDTH = 32.
module tb_alu_exec_seq;
    logic        clk = 1'b0, rst_n = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
    logic [1:0]  ALUop = 2'b00;
    logic [5:0]  Funct = 6'b0;
    logic [31:0] A = 32'd0, B = 32'd0;
    logic        in_ready, out_valid, Zero, DivByZero;
    logic [31:0] Result;
    logic [3:0]  ALUcont;
    int          vectors = 0, miscompares = 0;

    alu_exec_seq #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .ALUop(ALUop), .Funct(Funct), .A(A), .B(B),
        .out_valid(out_valid), .out_ready(out_ready), .Result(Result),
        .ALUcont(ALUcont), .Zero(Zero), .DivByZero(DivByZero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one op, wait for the result, optionally stall out_ready for `hold`
    // cycles, then drain it and confirm the block returns to idle.
    task automatic run(input string tag, input logic [1:0] op, input logic [5:0] fn,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp,
                       input logic [3:0] cont, input int lat, input logic dbz, input int hold);
        int   edges;
        logic busy_ok, stable;
        edges = 1;
        busy_ok = 1'b1;
        stable = 1'b1;
        @(negedge clk);
        check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        ALUop = op; Funct = fn; A = a; B = b; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        A = $urandom;
        B = $urandom;
        while (!out_valid && edges < 100) begin
            if (in_ready) busy_ok = 1'b0;
            @(posedge clk);
            #1 edges++;
        end
        check({tag, ".latency"}, 32'(edges), 32'(lat));
        check({tag, ".result"}, Result, exp);
        check({tag, ".alucont"}, 32'(ALUcont), 32'(cont));
        check({tag, ".zero"}, 32'(Zero), 32'(exp == 32'd0));
        check({tag, ".divbyzero"}, 32'(DivByZero), 32'(dbz));
        check({tag, ".busy"}, 32'(busy_ok), 32'd1);
        repeat (hold) begin
            @(posedge clk);
            #1;
            if (!out_valid || in_ready || Result !== exp || ALUcont !== cont || DivByZero !== dbz)
                stable = 1'b0;
        end
        check({tag, ".stable"}, 32'(stable), 32'd1);
        @(negedge clk) out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        check({tag, ".out_valid_drop"}, 32'(out_valid), 32'd0);
        check({tag, ".in_ready_back"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst.in_ready", 32'(in_ready), 32'd1);
        check("rst.out_valid", 32'(out_valid), 32'd0);
        check("rst.result", Result, 32'd0);
        check("rst.alucont", 32'(ALUcont), 32'd0);
        check("rst.zero", 32'(Zero), 32'd1);
        check("rst.divbyzero", 32'(DivByZero), 32'd0);
        @(negedge clk) rst_n = 1'b1;

        run("add",     2'b10, 6'b100000, 32'd5,          32'd7, 32'd12,         4'd2, 1, 1'b0, 0);
        run("beq",     2'b01, 6'b000000, 32'd3,          32'd3, 32'd0,          4'd6, 1, 1'b0, 0);
        run("slt",     2'b10, 6'b101010, 32'hFFFFFFFF,   32'd1, 32'd1,          4'd7, 1, 1'b0, 0);
        run("slt_neg", 2'b10, 6'b101010, 32'd1,   32'hFFFFFFFF, 32'd0,          4'd7, 1, 1'b0, 0);
        run("lw_wrap", 2'b00, 6'b111111, 32'hFFFFFFFF,   32'd2, 32'd1,          4'd2, 1, 1'b0, 0);
        run("ori",     2'b11, 6'b000000, 32'h000000F0, 32'h0F, 32'h000000FF,   4'd1, 1, 1'b0, 0);
        run("sub",     2'b10, 6'b100010, 32'd0,          32'd1, 32'hFFFFFFFF,   4'd6, 1, 1'b0, 0);
        run("and",     2'b10, 6'b100100, 32'hC,        32'hA, 32'h8,           4'd0, 1, 1'b0, 0);
        run("or",      2'b10, 6'b100101, 32'hC,        32'hA, 32'hE,           4'd1, 1, 1'b0, 0);
        run("dflt",    2'b10, 6'b111111, 32'd6,          32'd3, 32'd2,          4'd0, 1, 1'b0, 0);
        run("mul",     2'b10, 6'b011000, 32'h00010003,   32'd5, 32'h0005000F,   4'd3, 33, 1'b0, 0);
        run("mulwrap", 2'b10, 6'b011000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1,     4'd3, 33, 1'b0, 0);
        run("mulzero", 2'b10, 6'b011000, 32'h12345678,   32'd0, 32'd0,          4'd3, 33, 1'b0, 0);
`ifdef ALU_EXEC_SEQ_DIV_EN
        run("div",     2'b10, 6'b011010, 32'd100,        32'd7, 32'd14,         4'd4, 33, 1'b0, 0);
        run("div0",    2'b10, 6'b011010, 32'd9,          32'd0, 32'hFFFFFFFF,   4'd4, 1, 1'b1, 0);
        run("dbzclr",  2'b10, 6'b100000, 32'd1,          32'd1, 32'd2,          4'd2, 1, 1'b0, 0);
        run("divsml",  2'b10, 6'b011010, 32'd7,        32'd100, 32'd0,          4'd4, 33, 1'b0, 0);
        run("divmax",  2'b10, 6'b011010, 32'hFFFFFFFF,   32'd1, 32'hFFFFFFFF,   4'd4, 33, 1'b0, 0);
        run("divself", 2'b10, 6'b011010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1,     4'd4, 33, 1'b0, 0);
        run("divbig",  2'b10, 6'b011010, 32'hFFFFFFFF, 32'h10000, 32'h0000FFFF, 4'd4, 33, 1'b0, 0);
`else
        run("div_off", 2'b10, 6'b011010, 32'd100,        32'd7, 32'd4,          4'd0, 1, 1'b0, 0);
        run("div0off", 2'b10, 6'b011010, 32'd9,          32'd0, 32'd0,          4'd0, 1, 1'b0, 0);
`endif
        run("bp",      2'b10, 6'b100000, 32'd5,          32'd7, 32'd12,         4'd2, 1, 1'b0, 5);

        @(negedge clk);
        ALUop = 2'b10; Funct = 6'b011000; A = 32'h00010003; B = 32'd5; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rstmid.out_valid", 32'(out_valid), 32'd0);
        check("rstmid.in_ready", 32'(in_ready), 32'd1);
        check("rstmid.result", Result, 32'd0);
        check("rstmid.alucont", 32'(ALUcont), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        repeat (40) @(posedge clk);
        #1 check("rstmid.no_late_valid", 32'(out_valid), 32'd0);
        run("post_rst", 2'b10, 6'b100000, 32'd20,        32'd22, 32'd42,        4'd2, 1, 1'b0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
